// File: rtl/proc_pkg.sv
// Shared definitions for the pipeline stages: fetch state encoding and
// the opcode field layout used by the decode and execute stages.
package proc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } fetch_state_e;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;

  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_OUT  = 4'b1111;

  function automatic logic [3:0] get_opcode(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the program ROM from the PC, registers the
// returned word into an IR and hands it downstream over valid/ready.
module fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned INSTR_W      = 16,
  parameter bit          HALT_ON_WRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  localparam logic [ADDR_W-1:0] PC_ZERO = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_LAST = {ADDR_W{1'b1}};

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_data_q, ir_data_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               halted_q, halted_d;
  logic               load_s;
  logic               consume_s;

  assign load_s    = !ir_valid_q || ir_ready;
  assign consume_s = ir_valid_q && ir_ready;

  // Next-state: redirect beats load outside IDLE; the IR holds under backpressure.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_data_d  = ir_data_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;
    case (state_q)
      IDLE: begin
        if (consume_s) begin
          ir_valid_d = 1'b0;
        end else begin
          ir_valid_d = ir_valid_q;
        end
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          ir_valid_d = 1'b0;
        end else if (load_s) begin
          ir_data_d  = rom_instruction;
          ir_pc_d    = pc_q;
          ir_valid_d = 1'b1;
          if (HALT_ON_WRAP && (pc_q == PC_LAST)) begin
            state_d  = HALT;
            halted_d = 1'b1;
            pc_d     = PC_ZERO;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end else begin
          pc_d = pc_q;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          ir_valid_d = 1'b0;
          state_d    = RUN;
          halted_d   = 1'b0;
        end else if (consume_s) begin
          ir_valid_d = 1'b0;
        end else begin
          ir_valid_d = ir_valid_q;
        end
      end
      default: begin
        state_d    = IDLE;
        pc_d       = PC_ZERO;
        ir_valid_d = 1'b0;
        halted_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= PC_ZERO;
      ir_data_q  <= {INSTR_W{1'b0}};
      ir_pc_q    <= PC_ZERO;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_data_q  <= ir_data_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  assign rom_addr = pc_q;
  assign ir_data  = ir_data_q;
  assign ir_pc    = ir_pc_q;
  assign ir_valid = ir_valid_q;
  assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (halt-on-wrap and free-running) checked
// each cycle against a rule-level model, plus directed literal expectations.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        ir_ready;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;

  logic [3:0]  a_rom_addr, b_rom_addr;
  logic [15:0] a_rom_instr, b_rom_instr;
  logic [15:0] a_ir_data, b_ir_data;
  logic [3:0]  a_ir_pc, b_ir_pc;
  logic        a_ir_valid, b_ir_valid;
  logic        a_halted, b_halted;

  logic [15:0] rom [16];

  int n_vec = 0;
  int n_err = 0;

  // model state per instance: 0 = halt-on-wrap, 1 = wrap-around
  logic [3:0]  m_pc   [2];
  logic [15:0] m_ir   [2];
  logic [3:0]  m_irpc [2];
  logic        m_v    [2];
  logic        m_run  [2];
  logic        m_halt [2];

  assign a_rom_instr = rom[a_rom_addr];
  assign b_rom_instr = rom[b_rom_addr];

  fetch_unit #(.ADDR_W(4), .INSTR_W(16), .HALT_ON_WRAP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(a_rom_addr), .rom_instruction(a_rom_instr),
    .ir_data(a_ir_data), .ir_pc(a_ir_pc), .ir_valid(a_ir_valid),
    .ir_ready(ir_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(a_halted)
  );

  fetch_unit #(.ADDR_W(4), .INSTR_W(16), .HALT_ON_WRAP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(b_rom_addr), .rom_instruction(b_rom_instr),
    .ir_data(b_ir_data), .ir_pc(b_ir_pc), .ir_valid(b_ir_valid),
    .ir_ready(ir_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .halted(b_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    if (!m_run[i] && !m_halt[i]) begin
      if (m_v[i] && ir_ready) m_v[i] = 1'b0;
      if (start) m_run[i] = 1'b1;
    end else if (redirect_valid) begin
      m_pc[i]   = redirect_pc;
      m_v[i]    = 1'b0;
      m_run[i]  = 1'b1;
      m_halt[i] = 1'b0;
    end else if (m_run[i]) begin
      if (!m_v[i] || ir_ready) begin
        m_ir[i]   = rom[m_pc[i]];
        m_irpc[i] = m_pc[i];
        m_v[i]    = 1'b1;
        if (i == 0 && m_pc[i] == 4'd15) begin
          m_run[i]  = 1'b0;
          m_halt[i] = 1'b1;
          m_pc[i]   = 4'd0;
        end else begin
          m_pc[i] = m_pc[i] + 4'd1;
        end
      end
    end else begin
      if (m_v[i] && ir_ready) m_v[i] = 1'b0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_pc[i] = 4'd0; m_ir[i] = 16'd0; m_irpc[i] = 4'd0;
        m_v[i] = 1'b0; m_run[i] = 1'b0; m_halt[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i);
    end
  end

  // compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("a_rom_addr", {28'd0, a_rom_addr}, {28'd0, m_pc[0]});
      chk("a_ir_valid", {31'd0, a_ir_valid}, {31'd0, m_v[0]});
      chk("a_halted",   {31'd0, a_halted},   {31'd0, m_halt[0]});
      chk("b_rom_addr", {28'd0, b_rom_addr}, {28'd0, m_pc[1]});
      chk("b_ir_valid", {31'd0, b_ir_valid}, {31'd0, m_v[1]});
      chk("b_halted",   {31'd0, b_halted},   {31'd0, m_halt[1]});
      if (m_v[0]) begin
        chk("a_ir_data", {16'd0, a_ir_data}, {16'd0, m_ir[0]});
        chk("a_ir_pc",   {28'd0, a_ir_pc},   {28'd0, m_irpc[0]});
      end
      if (m_v[1]) begin
        chk("b_ir_data", {16'd0, b_ir_data}, {16'd0, m_ir[1]});
        chk("b_ir_pc",   {28'd0, b_ir_pc},   {28'd0, m_irpc[1]});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rom[0] = 16'h1203; rom[1] = 16'h1407; rom[2] = 16'h228F;
    for (int k = 3; k < 15; k++) rom[k] = 16'hF200;
    rom[15] = 16'hF400;

    rst_n = 1'b0; start = 1'b0; ir_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 4'd0;
    cyc(2);
    rst_n = 1'b1;
    chk("rst_valid", {31'd0, a_ir_valid}, 32'd0);
    chk("rst_addr",  {28'd0, a_rom_addr}, 32'd0);
    chk("rst_halt",  {31'd0, a_halted},   32'd0);

    // E0: start pulse
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    chk("first_data", {16'd0, a_ir_data}, 32'h1203);
    chk("first_pc",   {28'd0, a_ir_pc},   32'd0);
    cyc(1);
    chk("second_data", {16'd0, a_ir_data}, 32'h1407);
    cyc(1);
    chk("third_data", {16'd0, a_ir_data}, 32'h228F);
    cyc(12);
    chk("pc14_data", {16'd0, a_ir_data}, 32'hF200);
    cyc(1);
    chk("last_data",  {16'd0, a_ir_data}, 32'hF400);
    chk("last_pc",    {28'd0, a_ir_pc},   32'd15);
    chk("halt_rise",  {31'd0, a_halted},  32'd1);
    chk("last_valid", {31'd0, a_ir_valid}, 32'd1);
    cyc(1);
    chk("halt_drain", {31'd0, a_ir_valid}, 32'd0);
    chk("halt_hold",  {31'd0, a_halted},   32'd1);
    chk("wrap_pc",    {28'd0, b_ir_pc},    32'd0);
    chk("wrap_data",  {16'd0, b_ir_data},  32'h1203);
    chk("wrap_valid", {31'd0, b_ir_valid}, 32'd1);

    // redirect to 0 from HALT
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 4'd0;
    cyc(1);
    redirect_valid = 1'b0;
    chk("rdh_halted", {31'd0, a_halted},   32'd0);
    chk("rdh_valid",  {31'd0, a_ir_valid}, 32'd0);
    cyc(1);
    chk("rdh_data", {16'd0, a_ir_data}, 32'h1203);

    // backpressure for 5 cycles
    ir_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("bp_data", {16'd0, a_ir_data}, 32'h1203);
      chk("bp_pc",   {28'd0, a_ir_pc},   32'd0);
    end
    ir_ready = 1'b1;
    cyc(1);
    chk("bp_next", {16'd0, a_ir_data}, 32'h1407);
    chk("bp_npc",  {28'd0, a_ir_pc},   32'd1);

    // redirect to 2 while IR holds pc 5
    cyc(4);
    chk("pre_rd_pc", {28'd0, a_ir_pc}, 32'd5);
    redirect_valid = 1'b1; redirect_pc = 4'd2;
    cyc(1);
    redirect_valid = 1'b0;
    chk("rd_valid", {31'd0, a_ir_valid}, 32'd0);
    chk("rd_addr",  {28'd0, a_rom_addr}, 32'd2);
    cyc(1);
    chk("rd_data", {16'd0, a_ir_data}, 32'h228F);
    chk("rd_pc",   {28'd0, a_ir_pc},   32'd2);

    // asynchronous reset mid-stream at ir_pc 7
    cyc(5);
    chk("pre_rst_pc", {28'd0, a_ir_pc}, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data",  {16'd0, a_ir_data},  32'd0);
    chk("arst_pc",    {28'd0, a_ir_pc},    32'd0);
    chk("arst_valid", {31'd0, a_ir_valid}, 32'd0);
    chk("arst_addr",  {28'd0, a_rom_addr}, 32'd0);
    chk("arst_bdata", {16'd0, b_ir_data},  32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 4'd5;
    cyc(1);
    redirect_valid = 1'b0;
    chk("idle_addr",  {28'd0, a_rom_addr}, 32'd0);
    chk("idle_valid", {31'd0, a_ir_valid}, 32'd0);
    cyc(1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
    chk("restart_data", {16'd0, a_ir_data}, 32'h1203);
    chk("restart_pc",   {28'd0, a_ir_pc},   32'd0);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
